rotate_arbiter: RTL and testbench
=================================

# rotate_arbiter

Shares one 16-bit combinational left-rotator between two requesters. Each requester issues rotate-left or rotate-right operations over a valid/ready handshake. The block arbitrates round-robin, sequences one operation at a time through the rotator, and returns the registered result on that requester's response port. It sits between the instruction/control logic and the rotate datapath of the ALU.

## Interface
Parameters:
- FIRST_PRIO, default 0: requester that wins the first contended grant after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_data  in  16  operand
- req0_amt  in  4  rotate amount 0..15
- req0_dir  in  1  0 = rotate left, 1 = rotate right
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_data  out  16  result
- req1_*, rsp1_*: identical set for requester 1
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - grant = the only valid requester.
  - If both are valid, grant = the requester not in last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. It is combinational and at most one is high.
  - On a handshake: latch data, effective amount and owner; update last_grant := owner; go to EXEC.
- Effective amount = dir ? (16 − amt) mod 16 : amt, computed in 4-bit two's complement (−amt). amt=0 with either dir gives identity.
- EXEC: rotator output registered into result register; go to DONE.
- DONE: rsp_valid of the owner high and the other low. rsp_data = result register, held stable. On owner's rsp_ready: go to IDLE.
- rspN_data is driven from the shared result register regardless of owner. It is only meaningful while rspN_valid.
- No new request is accepted until the response handshake completes. A request arriving while busy waits; its valid must stay asserted and its operands held (source obligation).
- rsp_ready of the non-owner is ignored.
- Reset (rst_n=0 at an edge, any state): state=IDLE; last_grant = 1−FIRST_PRIO; all ready/valid outputs 0; result register 0x0000; busy=0. An in-flight operation is discarded with no response.

## Timing
- Request handshake at edge N (ready&&valid sampled). State is EXEC during cycle N..N+1. rsp_valid is high from after edge N+1 (latency 2 cycles, accept to result visible).
- Response handshake at edge M returns to IDLE. The earliest next accept is edge M+1. Peak throughput is 1 op / 3 cycles.
- Same-cycle rsp_ready with rsp_valid completes the operation. rsp_valid deasserts after that edge.
- Arbitration is re-evaluated every IDLE cycle. A requester dropping valid before ready causes no grant and no last_grant update.
- Outputs come from registered state. reqN_ready additionally depends combinationally on reqN_valid/reqN+1 valid.

## Structure
- Shared package rotate_pkg holds the state enum (IDLE, EXEC, DONE), WIDTH=16, AMT_W=4, and the DIR_LEFT/DIR_RIGHT constants.
- Sub-module rotl16: purely combinational 16-bit rotate-left by 4-bit amount. It is instantiated once and is the only rotator in the block.
- Arbitration (grant + last_grant) lives in the top module, not a separate sub-module.

## Test plan
- Single op: req0 data=0x8001, amt=1, dir=0, accepted edge N → rsp0_valid from after edge N+1, data=0x0003; rsp1_valid stays 0.
- Right rotate and identity:
  - req1 0x1234, amt=4, dir=1 → 0x4123.
  - 0xBEEF, amt=0, dir=1 → 0xBEEF.
  - 0x0001, amt=15, dir=0 → 0x8000.
- Contention after reset (FIRST_PRIO=0): both valid continuously, req0=0x00F0/amt 4/left, req1=0x00F0/amt 4/right.
  - Grants go req0 → 0x0F00, then req1 → 0x000F, then req0 again.
  - Only one ready is high per cycle.
- Backpressure: hold rsp0_ready=0 for 5 cycles in DONE → rsp0_valid and rsp0_data stable, req1_ready stays 0, busy=1. Asserting rsp0_ready returns to IDLE next edge.
- Reset mid-operation: assert rst_n=0 in EXEC → next edge busy=0, all valids/readies 0, no response emitted. After release with FIRST_PRIO=0, req0 wins the first contended grant.
- Exhaustive: all 16 amounts × both dirs on 0xA5C3 against a reference rotate model, via random requester interleaving and random rsp_ready stalls.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotate arbiter: FSM states, datapath
// widths, direction encoding and the left-equivalent rotate amount.
package rotate_pkg;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A right rotate by amt equals a left rotate by (-amt) mod 2**AMT_W.
    function automatic logic [AMT_W-1:0] eff_amt(input logic [AMT_W-1:0] amt,
                                                 input logic dir);
        return (dir == DIR_RIGHT) ? ({AMT_W{1'b0}} - amt) : amt;
    endfunction

endpackage

// File: rtl/rotl16.sv
// Purely combinational 16-bit rotate-left by a 4-bit amount.
module rotl16
    import rotate_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] doubled;

    // Shifting the doubled word left leaves the wrapped bits in the upper half.
    assign doubled = {data, data} << amt;
    assign result  = doubled[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin sharing of one rotl16 between two requesters; one operation in
// flight at a time, result returned from a registered result register.
module rotate_arbiter
    import rotate_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid and payload must stay stable until then, ready may depend on valid.

    // last_grant starts as the loser so FIRST_PRIO wins the first contention.
    localparam logic RESET_LAST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_t           state, state_next;
    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             accept;
    logic             owner_rsp_ready;
    logic [WIDTH-1:0] op_data;
    logic [AMT_W-1:0] op_amt;
    logic [WIDTH-1:0] rot_out;
    logic [WIDTH-1:0] result;

    rotl16 u_rotl16 (
        .data   (op_data),
        .amt    (op_amt),
        .result (rot_out)
    );

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready      = (state == IDLE) && req0_valid && !grant;
    assign req1_ready      = (state == IDLE) && req1_valid && grant;
    assign accept          = req0_ready || req1_ready;
    assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (owner_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= RESET_LAST;
            owner      <= 1'b0;
            op_data    <= '0;
            op_amt     <= '0;
            result     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
                op_data    <= grant ? req1_data : req0_data;
                op_amt     <= grant ? eff_amt(req1_amt, req1_dir)
                                    : eff_amt(req0_amt, req0_dir);
            end
            if (state == EXEC) begin
                result <= rot_out;
            end
        end
    end

    assign rsp0_valid = (state == DONE) && !owner;
    assign rsp1_valid = (state == DONE) && owner;
    assign rsp0_data  = result;
    assign rsp1_data  = result;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_rotate_arbiter.sv
// Scenario-driven bench for rotate_arbiter with a tagged expected-result queue
// popped by a response monitor.
module tb_rotate_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  req0_amt, req1_amt;
    logic        req0_dir, req1_dir;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [15:0] rsp0_data, rsp1_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // {requester, result}
    logic [16:0] exp_q[$];

    rotate_arbiter #(.FIRST_PRIO(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_rot(input logic [15:0] d, input logic [3:0] a,
                                            input logic dir);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (dir == 1'b0) r[(i + int'(a)) % 16] = d[i];
            else             r[i] = d[(i + int'(a)) % 16];
        end
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_req(input int n, input logic v, input logic [15:0] d,
                           input logic [3:0] a, input logic dir);
        if (n == 0) begin
            req0_valid = v; req0_data = d; req0_amt = a; req0_dir = dir;
        end else begin
            req1_valid = v; req1_data = d; req1_amt = a; req1_dir = dir;
        end
    endtask

    function automatic logic get_ready(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic get_rsp_valid(input int n);
        return (n == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    task automatic set_rsp_ready(input int n, input logic v);
        if (n == 0) rsp0_ready = v;
        else        rsp1_ready = v;
    endtask

    // Waits for the owner's response, stalls, then takes it for one edge.
    task automatic finish_rsp(input int n, input int stall);
        bit ok;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (get_rsp_valid(n)) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rsp_timeout: rsp%0d_valid=0, required 1", n);
            return;
        end
        repeat (stall) @(posedge clk);
        @(posedge clk); #1;
        set_rsp_ready(n, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(n, 1'b0);
        @(negedge clk);
        total++;
        if (get_rsp_valid(n) !== 1'b0) begin
            bad++;
            $display("FAIL rsp_drop: rsp%0d_valid=%b after handshake, required 0",
                     n, get_rsp_valid(n));
        end
    endtask

    task automatic do_op(input int n, input logic [15:0] d, input logic [3:0] a,
                         input logic dir, input int stall);
        bit ok;
        @(posedge clk); #1;
        set_req(n, 1'b1, d, a, dir);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (get_ready(n)) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout: req%0d_ready=0, required 1", n);
            set_req(n, 1'b0, d, a, dir);
            return;
        end
        exp_q.push_back({n[0], ref_rot(d, a, dir)});
        @(posedge clk); #1;
        set_req(n, 1'b0, 16'h0, 4'h0, 1'b0);
        finish_rsp(n, stall);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((rsp0_valid && rsp1_valid) || (req0_ready && req1_ready)) begin
                bad++;
                $display("FAIL onehot: rsp_valid=%b%b req_ready=%b%b, required at most one each",
                         rsp1_valid, rsp0_valid, req1_ready, req0_ready);
            end
            if (rsp0_valid && rsp0_ready || rsp1_valid && rsp1_ready) begin
                logic [16:0] got;
                got = rsp1_valid ? {1'b1, rsp1_data} : {1'b0, rsp0_data};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got req%0d data=%h, required no response",
                             got[16], got[15:0]);
                end else begin
                    logic [16:0] exp;
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL sb_data: got req%0d data=%h, required req%0d data=%h",
                                 got[16], got[15:0], exp[16], exp[15:0]);
                    end
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy/rv0/rv1/rr0/rr1=%b, required 00000",
                     {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        total++;
        if (rsp0_data !== 16'h0000 || rsp1_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_result: rsp0=%h rsp1=%h, required 0000", rsp0_data, rsp1_data);
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'h8001, 4'd1, 1'b0);
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready: req0_ready=%b, required 1", req0_ready);
        end
        exp_q.push_back({1'b0, 16'h0003});
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_exec: busy=%b rsp0_valid=%b, required 1 0", busy, rsp0_valid);
        end
        @(negedge clk);
        total++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_data !== 16'h0003) begin
            bad++;
            $display("FAIL single_done: rv0=%b rv1=%b data=%h, required 1 0 0003",
                     rsp0_valid, rsp1_valid, rsp0_data);
        end
        finish_rsp(0, 0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_patterns();
        do_op(1, 16'h1234, 4'd4, 1'b1, 0);
        do_op(0, 16'hBEEF, 4'd0, 1'b1, 1);
        do_op(1, 16'h0001, 4'd15, 1'b0, 0);
    endtask

    task automatic test_contention();
        int exp_owner[3] = '{0, 1, 0};
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        apply_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'h00F0, 4'd4, 1'b0);
        set_req(1, 1'b1, 16'h00F0, 4'd4, 1'b1);
        for (int g = 0; g < 3; g++) begin
            bit ok;
            int seen;
            ok = 0;
            seen = 0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    ok = 1;
                    seen = req1_ready ? 1 : 0;
                end
            end
            total++;
            if (!ok || seen != exp_owner[g]) begin
                bad++;
                $display("FAIL contend_grant%0d: granted req%0d (seen=%0d), required req%0d",
                         g, seen, ok, exp_owner[g]);
            end
            if (ok) begin
                exp_q.push_back({seen[0], (seen == 0) ? 16'h0F00 : 16'h000F});
                @(posedge clk);
            end
        end
        #1;
        set_req(0, 1'b0, 16'h0, 4'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 4'h0, 1'b0);
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL contend_drain: busy=%b, required 0", busy);
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp0;
        bit ok;
        exp0 = ref_rot(16'h1357, 4'd3, 1'b0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'h1357, 4'd3, 1'b0);
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept: req0_ready=%b, required 1", req0_ready);
        end
        exp_q.push_back({1'b0, exp0});
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 4'h0, 1'b0);
        set_req(1, 1'b1, 16'h00FF, 4'd8, 1'b1);
        rsp1_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (rsp0_valid) ok = 1;
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== exp0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: rv0=%b data=%h rr1=%b busy=%b, required 1 %h 0 1",
                         c, rsp0_valid, rsp0_data, req1_ready, busy, exp0);
            end
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: busy=%b rv0=%b rr1=%b, required 0 0 1",
                     busy, rsp0_valid, req1_ready);
        end
        exp_q.push_back({1'b1, ref_rot(16'h00FF, 4'd8, 1'b1)});
        @(posedge clk); #1;
        set_req(1, 1'b0, 16'h0, 4'h0, 1'b0);
        rsp1_ready = 1'b0;
        finish_rsp(1, 2);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'h1111, 4'd2, 1'b0);
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_accept: req0_ready=%b, required 1", req0_ready);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 4'h0, 1'b0);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0 ||
            rsp0_data !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset: busy/rv0/rv1/rr0/rr1=%b data=%h, required 00000 0000",
                     {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, rsp0_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 16'h0003, 4'd1, 1'b0);
        set_req(1, 1'b1, 16'h0003, 4'd1, 1'b1);
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_regrant: rr0=%b rr1=%b rv0=%b, required 1 0 0",
                     req0_ready, req1_ready, rsp0_valid);
        end
        exp_q.push_back({1'b0, ref_rot(16'h0003, 4'd1, 1'b0)});
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 4'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 4'h0, 1'b0);
        finish_rsp(0, 0);
    endtask

    task automatic test_exhaustive();
        for (int a = 0; a < 16; a++) begin
            for (int d = 0; d < 2; d++) begin
                do_op($urandom_range(0, 1), 16'hA5C3, 4'(a), d[0], $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, 16'h0, 4'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 4'h0, 1'b0);

        test_reset();
        test_single();
        test_patterns();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d results never returned, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
